// File: rtl/cpmg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpmg_pkg
// Brief   : Shared types and constants for the CPMG pulse sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package cpmg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP90  = 3'd1,
        SETUP180 = 3'd2,
        LOAD     = 3'd3,
        FIRE     = 3'd4,
        TAIL     = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [1:0] c_addr_w90    = 2'd0;
    localparam logic [1:0] c_addr_w180   = 2'd1;
    localparam logic [1:0] c_addr_period = 2'd2;
    localparam logic [1:0] c_addr_count  = 2'd3;

    localparam int MIN_INTERVAL = 8;

endpackage
`default_nettype wire

// File: rtl/nmr_interval_timer.sv
`default_nettype none
// ============================================================================
// Module  : nmr_interval_timer
// Brief   : Free-running interval counter with synchronous clear and a
//           terminal flag raised when the count equals a programmable limit.
// Revision: 1.0 - initial release
// ============================================================================
module nmr_interval_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic [PERIOD_W-1:0] limit,
    output logic                terminal
);

    localparam logic [PERIOD_W-1:0] c_one = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_one;
        end
    end

    assign terminal = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/cpmg_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cpmg_pulse_sequencer
// Brief   : Plays one CPMG train (90 deg pulse + N 180 deg pulses) into the
//           H-bridge drive stage: width word, load strobe and run enable.
// Revision: 1.0 - initial release
// ============================================================================
module cpmg_pulse_sequencer
    import cpmg_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] width_out,
    output logic        load_out,
    output logic        bridge_en,
    output logic        echo_tick,
    output logic        busy,
    output logic        done
);

    localparam logic [PERIOD_W-1:0] c_min_iv    = PERIOD_W'(MIN_INTERVAL);
    localparam logic [PERIOD_W-1:0] c_one_p     = PERIOD_W'(1);
    localparam logic [COUNT_W-1:0]  c_one_c     = COUNT_W'(1);

    state_t               r_state;
    state_t               w_next;
    logic [15:0]          r_w90;
    logic [15:0]          r_w180;
    logic [PERIOD_W-1:0]  r_period;
    logic [COUNT_W-1:0]   r_count;
    logic [COUNT_W-1:0]   r_remain;
    logic                 r_first;
    logic [15:0]          r_width;

    logic [PERIOD_W-1:0]  w_half;
    logic [PERIOD_W-1:0]  w_first_iv;
    logic [PERIOD_W-1:0]  w_later_iv;
    logic [PERIOD_W-1:0]  w_limit;
    logic                 w_terminal;
    logic                 w_enter_setup;
    logic                 w_idle;

    assign w_idle = (r_state == IDLE);

    // Configuration is frozen for the whole train.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w90    <= '0;
            r_w180   <= '0;
            r_period <= '0;
            r_count  <= '0;
        end else if (cfg_we && w_idle) begin
            case (cfg_addr)
                c_addr_w90:    r_w90    <= cfg_data;
                c_addr_w180:   r_w180   <= cfg_data;
                c_addr_period: r_period <= PERIOD_W'(cfg_data);
                c_addr_count:  r_count  <= COUNT_W'(cfg_data);
                default:       r_w90    <= r_w90;
            endcase
        end
    end

    assign w_half     = r_period >> 1;
    assign w_first_iv = (w_half   < c_min_iv) ? c_min_iv : w_half;
    assign w_later_iv = (r_period < c_min_iv) ? c_min_iv : r_period;
    assign w_limit    = (r_first ? w_first_iv : w_later_iv) - c_one_p;

    assign w_enter_setup = (w_next == SETUP90) || (w_next == SETUP180);

    nmr_interval_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .en       (!w_idle),
        .clr      (w_enter_setup),
        .limit    (w_limit),
        .terminal (w_terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Once the last pulse is fired, TAIL finishes out its interval.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (start) w_next = SETUP90;
            SETUP90:  w_next = LOAD;
            SETUP180: w_next = LOAD;
            LOAD:     w_next = FIRE;
            FIRE: begin
                if (w_terminal) begin
                    w_next = (r_remain != '0) ? SETUP180 : DONE;
                end else if (r_remain == '0) begin
                    w_next = TAIL;
                end
            end
            TAIL:     if (w_terminal) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
        if (stop) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_remain <= '0;
            r_first  <= 1'b0;
            r_width  <= '0;
        end else begin
            if (w_next == SETUP90) begin
                r_remain <= r_count;
                r_first  <= 1'b1;
                r_width  <= r_w90;
            end else if (w_next == SETUP180) begin
                r_remain <= r_remain - c_one_c;
                r_first  <= 1'b0;
                r_width  <= r_w180;
            end
        end
    end

    always_comb begin
        load_out  = 1'b0;
        bridge_en = 1'b0;
        echo_tick = 1'b0;
        done      = 1'b0;
        busy      = !w_idle;
        case (r_state)
            SETUP180: echo_tick = 1'b1;
            LOAD:     load_out  = 1'b1;
            FIRE:     bridge_en = 1'b1;
            TAIL:     bridge_en = 1'b1;
            DONE:     done      = 1'b1;
            default:  done      = 1'b0;
        endcase
    end

    assign width_out = r_width;

endmodule
`default_nettype wire
